// File: rtl/sub_pipe_bk.sv
// sub_pipe_bk: two-stage pipelined subtractor, diff = a - b - bin.
// Stage 1 registers the generate/propagate terms of a + ~b + ~bin.
// A Brent-Kung prefix tree then resolves the carries, and stage 2 registers diff/bout/ovf.
// A valid/ready handshake is used on both sides. in_ready depends combinationally on out_ready.

module sub_pipe_bk #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic             s1_cin_q, s1_cin_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             s2_adv;
    logic             s1_adv;

    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf_calc;

    // A stage may advance when it is empty or when its successor is advancing.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    // Stage 1 next state: operands are captured only on an input handshake.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_cin_d   = s1_cin_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_g_d   = a & ~b;
                s1_p_d   = a ^ ~b;
                s1_cin_d = ~bin;
            end
        end
    end

    // Brent-Kung carry tree. The carry-in is folded into bit 0, so gg[i] becomes the carry into bit i+1.
    always_comb begin
        int half;
        int stride;
        int j;
        gg    = s1_g_q;
        pp    = s1_p_q;
        gg[0] = s1_g_q[0] | (s1_p_q[0] & s1_cin_q);
        // up-sweep: build group terms at positions stride-1 (mod stride)
        for (int l = 0; l < LEVELS; l++) begin
            half   = 1 << l;
            stride = 2 << l;
            for (int i = 0; i < WIDTH; i++) begin
                j = (i >= half) ? (i - half) : 0;
                if ((i % stride) == (stride - 1)) begin
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        // down-sweep: fill in the remaining prefixes from the completed ones
        for (int l = LEVELS - 1; l >= 0; l--) begin
            half   = 1 << l;
            stride = 2 << l;
            for (int i = 0; i < WIDTH; i++) begin
                j = (i >= half) ? (i - half) : 0;
                if ((i >= stride) && ((i % stride) == (half - 1))) begin
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                end
            end
        end
    end

    // Sum and flags. The MSB of p is 0 exactly when a and b differ in sign.
    // In that case g[MSB] equals a[MSB], so no separate copy of the sign bit is needed.
    always_comb begin
        carry     = {gg[WIDTH-2:0], s1_cin_q};
        sum       = s1_p_q ^ carry;
        carry_out = gg[WIDTH-1];
        ovf_calc  = !s1_p_q[WIDTH-1] && (sum[WIDTH-1] != s1_g_q[WIDTH-1]);
    end

    // Stage 2 next state: results are held until the downstream side accepts them.
    always_comb begin
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = sum;
                bout_d = !carry_out;
                ovf_d  = ovf_calc;
            end
        end
    end

    // Pipeline registers. Reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sub_pipe_bk.sv
// tb_sub_pipe_bk: randomized and directed stimulus for sub_pipe_bk.
// A queue-based reference model (plain arithmetic) checks the DUT.

module tb_sub_pipe_bk;

    localparam int W = 16;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_in = 0;
    int n_out = 0;

    // expected results in order, packed as {bout, ovf, diff}
    logic [W+1:0] exp_q[$];
    logic         fresh = 1'b0;

    always #5 clk = ~clk;

    sub_pipe_bk #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        longint ux, uy, sx, sy, ci, ur, sr;
        logic [W-1:0] d;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ci = longint'(c);
        ur = ux - uy - ci;
        sr = sx - sy - ci;
        d  = ur[W-1:0];
        return {(ur < 0), ((sr < SMIN) || (sr > SMAX)), d};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // One clock cycle: drive at negedge, check against the model, advance the model.
    task automatic cycle(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tbin, input logic tor);
        logic         exp_rdy;
        logic         exp_ov;
        logic [W+1:0] front;
        @(negedge clk);
        in_valid  = iv;
        a         = ta;
        b         = tb_v;
        bin       = tbin;
        out_ready = tor;
        #1;
        exp_rdy = (exp_q.size() < 2) || tor;
        exp_ov  = (exp_q.size() >= 2) || ((exp_q.size() == 1) && !fresh);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            front = exp_q[0];
            check("diff", 64'(diff), 64'(front[W-1:0]));
            check("bout", 64'(bout), 64'(front[W+1]));
            check("ovf", 64'(ovf), 64'(front[W]));
        end
        if (in_valid && in_ready) n_in++;
        if (out_valid && out_ready) n_out++;
        if (exp_ov && tor) void'(exp_q.pop_front());
        fresh = iv && exp_rdy;
        if (fresh) exp_q.push_back(ref_sub(ta, tb_v, tbin));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        bin       = 1'($urandom);
        out_ready = 1'($urandom);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        exp_q.delete();
        fresh = 1'b0;
        n_in  = 0;
        n_out = 0;
    endtask

    initial begin
        do_reset(2);

        // directed: simple difference with a two-cycle latency
        cycle(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("s1_diff", 64'(diff), 64'h1000);
        check("s1_bout", 64'(bout), 64'(0));

        // directed: wrap below zero, then signed overflow
        cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("wrap_diff", 64'(diff), 64'hFFFF);
        check("wrap_bout", 64'(bout), 64'(1));
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("ovf_diff", 64'(diff), 64'h7FFF);
        check("ovf_flag", 64'(ovf), 64'(1));
        repeat (2) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // 100 back-to-back operand sets at full rate
        repeat (100) cycle(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b1);
        repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("stream_count", 64'(n_out), 64'(n_in));

        // fill while stalled: the third set is refused until out_ready rises
        cycle(1'b1, 16'h0500, 16'h0100, 1'b0, 1'b0);
        cycle(1'b1, 16'h0300, 16'h0400, 1'b1, 1'b0);
        cycle(1'b1, 16'h7000, 16'h9000, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'(0));
        repeat (3) cycle(1'b1, 16'h7000, 16'h9000, 1'b0, 1'b0);
        check("held_diff", 64'(diff), 64'h0400);
        cycle(1'b1, 16'h7000, 16'h9000, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // reset while both stages hold data; the flushed data must not appear
        cycle(1'b1, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBBB, 16'h2222, 1'b0, 1'b0);
        do_reset(1);
        repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // random handshake toggling
        repeat (10000) cycle(1'(($urandom % 4) != 0), rnd_op(), rnd_op(), 1'($urandom),
                             1'(($urandom % 3) != 0));
        repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("random_count", 64'(n_out), 64'(n_in));
        check("random_drained", 64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_pipe_bk.md
SUB_PIPE_BK -- requirements
Module: sub_pipe_bk

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand and result width in bits, with legal values 4 to 64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream offers an operand set.
REQ-005 SHALL have port: in_ready  output  1  block accepts the operand set this cycle.
REQ-006 SHALL have port: a  input  WIDTH  minuend, unsigned or two's complement.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  result is presented.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port: diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
REQ-013 SHALL have port: ovf  output  1  signed overflow of a - b - bin.

Function
REQ-014 SHALL compute the result as a + ~b + ~bin using a Brent-Kung parallel-prefix carry network, with carry-in = ~bin, so that bout = ~carry_out.
REQ-015 SHALL compute ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
REQ-016 SHALL use two register stages: S1 holds the registered generate/propagate terms and carry-in; S2 holds the registered diff, bout and ovf; the prefix tree and sum XOR lie between S1 and S2.
REQ-017 SHALL transfer on the input side only when in_valid & in_ready; SHALL transfer on the output side only when out_valid & out_ready.
REQ-018 SHALL set s2_adv = !s2_valid | out_ready and s1_adv = !s1_valid | s2_adv; in_ready SHALL equal s1_adv.
REQ-019 SHALL have a latency of 2 cycles from input handshake to out_valid when no stall occurs; out_valid SHALL equal s2_valid.
REQ-020 SHALL sustain a throughput of 1 result per cycle while out_ready is held high.
REQ-021 SHALL hold diff, bout and ovf stable while out_valid=1 and out_ready=0, through stalls of any length.
REQ-022 SHALL, when full (S1 and S2 valid, out_ready=0), drive in_ready=0 and leave a, b and bin unsampled.
REQ-023 SHALL, on a simultaneous output pop and input push while full, advance S1 into S2 and load new operands into S1 in the same cycle, with no bubble and no data loss.
REQ-024 SHALL, when S1 is empty and out_ready=0, still accept one operand set into S1 (in_ready=1).
REQ-025 SHALL ignore operand values in cycles without an input handshake; stage valid bits SHALL clear when a stage empties.
REQ-026 SHALL wrap results modulo 2^WIDTH (for example 0 - 1 gives all-ones with bout=1).
REQ-027 SHALL ensure no combinational path from a, b or bin to any output; the out_ready-to-in_ready combinational path is permitted.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear s1_valid and s2_valid, so that out_valid=0 and in_ready=1 in the following cycle.
REQ-029 SHALL reset diff, bout and ovf to 0.
REQ-030 SHALL discard any in-flight operands on a mid-operation reset and produce no result for them.
REQ-031 SHALL take precedence for rst over any simultaneous handshake.

Verification
REQ-032 SHALL pass this scenario: WIDTH=16, a=0x1234, b=0x0234, bin=0, out_ready=1 -> 2 cycles later diff=0x1000, bout=0, ovf=0.
REQ-033 SHALL pass this scenario: a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1, ovf=0; and a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-034 SHALL pass this scenario: back-to-back stream of 100 random operand sets with out_ready=1 -> 100 results in order, one per cycle, every result matching the reference model.
REQ-035 SHALL pass this scenario: push 3 operand sets with out_ready=0 -> third set refused (in_ready=0), out_valid=1, diff held; raise out_ready -> 2 results drained in order, then the third set accepted.
REQ-036 SHALL pass this scenario: assert rst for 1 cycle while S1 and S2 are valid -> next cycle out_valid=0, diff=0, in_ready=1; the flushed operands never appear at the output.
REQ-037 SHALL pass this scenario: random in_valid/out_ready toggling for 10k cycles -> scoreboard reports no loss, duplication or reordering, and outputs are stable under stall.
